uartdev: RTL and testbench
==========================

UARTDEV -- requirements
Module: uartdev

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning TX FIFO entries; power of two, minimum 2.
REQ-002 SHALL have parameter DIV_DEFAULT, default 16'd434, meaning the reset value of the bit-period divisor in clk cycles.
REQ-003 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port wen  input  1  bus write strobe, already decoded for this device.
REQ-006 SHALL have port waddr  input  2  word offset of the write (devaddr[3:2]).
REQ-007 SHALL have port wdata  input  32  bus write data.
REQ-008 SHALL have port ren  input  1  bus read strobe, already decoded for this device.
REQ-009 SHALL have port raddr  input  2  word offset of the read.
REQ-010 SHALL have port rdata  output  32  registered read data.
REQ-011 SHALL have port txd  output  1  serial transmit line; idles high.
REQ-012 SHALL have port irq  output  1  high while the FIFO is empty and the transmitter is idle.

Function
REQ-013 Register map (word offsets):
- 0 DATA, write-only: wdata[7:0] pushed to the FIFO.
- 1 STATUS, read-only: bit0 full, bit1 empty, bit2 busy, bit3 overflow, bits[11:8] count, other bits 0.
- 2 DIV, read/write: bits[15:0].
- 3: reserved.
REQ-014 Write handling:
- DATA write while the FIFO is full is dropped and sets sticky overflow, even if a pop occurs in the same cycle.
- Writes to offsets 1 and 3 are ignored.
REQ-015 Read timing: rdata updates on the edge after ren is high and then holds its value. Reads of DATA or offset 3 return 0.
REQ-016 A STATUS read clears overflow on the same edge; rdata returns the pre-clear value. If a set and a clear occur in the same cycle, set wins.
REQ-017 A DIV write of 0 is stored as 1.
REQ-018 The transmitter latches DIV at frame start. A DIV change never alters a frame already in progress.
REQ-019 FSM states and transitions:
- IDLE -> START when the FIFO is not empty; pop the head byte into a shift register on this transition.
- START -> DATA -> PARITY -> STOP, or START -> DATA -> STOP without parity.
- STOP -> START if the FIFO is not empty (back-to-back frames, no idle gap), else STOP -> IDLE.
REQ-020 Each state lasts exactly DIV clk cycles, counted by a 16-bit down counter.
REQ-021 Line levels per state:
- IDLE: txd=1.
- START: txd=0.
- DATA: 8 bits, LSB first, each held DIV cycles.
- STOP: txd=1.
REQ-022 busy is 1 in every state except IDLE.
REQ-023 FIFO counters:
- count = number of entries; full = (count==FIFO_DEPTH); empty = (count==0).
- Pointers wrap modulo FIFO_DEPTH.
- A simultaneous accepted push and pop leaves count unchanged.
REQ-024 txd is driven from a register, with no combinational path from any bus input.

Reset
REQ-025 While rst_n is low, outputs and state SHALL hold these values:
- txd=1, rdata=0, irq=1;
- FSM=IDLE, FIFO empty, overflow=0, DIV=DIV_DEFAULT.
REQ-026 Reset mid-frame aborts the frame immediately; txd returns to 1 asynchronously.

Configuration
REQ-027 With UARTDEV_PARITY_EN defined:
- the PARITY state exists and transmits the even parity bit (XOR of the 8 data bits);
- the frame is 11 bits.
REQ-028 Without UARTDEV_PARITY_EN, the PARITY state and its logic are absent and the frame is 10 bits.

Verification
REQ-029 DIV=4; write DATA=0x55 -> txd sequence 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles; with parity, an additional bit 0 before the stop bit. irq falls, then rises 1 cycle after STOP ends.
REQ-030 DIV=2; write 9 bytes back-to-back while idle -> first byte is popped immediately, all 8 further writes accepted, STATUS shows count=8 and full=1, overflow=0. A 10th write sets overflow=1. The next STATUS read returns bit3=1, and the following read returns bit3=0.
REQ-031 Write DIV=0, then read DIV -> rdata=1 on the next cycle. Transmit 0xFF -> each bit lasts 1 cycle.
REQ-032 Mid-frame of 0xA3 at DIV=8, write DIV=3 -> the current frame keeps 8-cycle bits; the next queued byte uses 3-cycle bits.
REQ-033 Assert rst_n low during DATA bit 4 -> txd=1 immediately. After release: STATUS=0x2 (empty), DIV reads 434, irq=1.
REQ-034 Queue 0x01 and 0x80 -> the second START begins on the cycle after the first STOP ends, with no idle cycles between frames.

Source files
------------

// File: rtl/uartdev.sv
// Bus-mapped UART transmitter: TX FIFO, programmable bit divisor, STATUS/DIV registers.
// Define UARTDEV_PARITY_EN to add an even-parity bit (11-bit frame instead of 10).
module uartdev #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DIV_DEFAULT = 16'd434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wen,
    input  logic [1:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        ren,
    input  logic [1:0]  raddr,
    output logic [31:0] rdata,
    output logic        txd,
    output logic        irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_DIV    = 2'd2;

`ifdef UARTDEV_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    // FIFO storage and bookkeeping
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [3:0]       w_count4;

    // Register file
    logic             r_ovf;
    logic             w_ovf_set;
    logic             w_ovf_clr;
    logic [15:0]      r_div;
    logic [31:0]      r_rdata;
    logic [31:0]      w_rdata_nxt;

    // Transmitter
    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_cnt;
    logic [15:0]      r_div_lat;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic [2:0]       r_bit;
    logic             r_txd;
    logic             w_txd_nxt;
    logic             r_irq;
    logic             w_tick;
    logic             w_busy;
`ifdef UARTDEV_PARITY_EN
    logic             r_parity;
`endif

    logic             w_unused;
    assign w_unused = ^wdata[31:16];

    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_count4  = 4'(r_count);
    // Full is the pre-edge value, so a push is dropped even when a pop lands on the same edge.
    assign w_push    = wen && (waddr == A_DATA) && !w_full;
    assign w_ovf_set = wen && (waddr == A_DATA) && w_full;
    assign w_ovf_clr = ren && (raddr == A_STATUS);
    assign w_tick    = (r_cnt == 16'd0);
    assign w_busy    = (r_state != S_IDLE);

    assign rdata = r_rdata;
    assign txd   = r_txd;
    assign irq   = r_irq;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_rdata_nxt = 32'd0;
        case (raddr)
            A_STATUS: w_rdata_nxt = {20'd0, w_count4, 4'd0, r_ovf, w_busy, w_empty, w_full};
            A_DIV:    w_rdata_nxt = {16'd0, r_div};
            default:  w_rdata_nxt = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= DIV_DEFAULT;
            r_ovf   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            if (wen && (waddr == A_DIV)) begin
                r_div <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
            end
            // Set wins over the clear from a STATUS read in the same cycle.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (ren) begin
                r_rdata <= w_rdata_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_shift_nxt = r_shift;
        w_txd_nxt   = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = S_START;
                    w_pop       = 1'b1;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick && (r_bit == 3'd7)) begin
`ifdef UARTDEV_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef UARTDEV_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Back-to-back frames: go straight to the next start bit with no idle gap.
                if (w_tick) begin
                    if (!w_empty) begin
                        w_state_nxt = S_START;
                        w_pop       = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_pop) begin
            w_shift_nxt = r_mem[r_rptr];
        end else if ((r_state == S_DATA) && w_tick) begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
        end

        case (w_state_nxt)
            S_START:  w_txd_nxt = 1'b0;
            S_DATA:   w_txd_nxt = w_shift_nxt[0];
`ifdef UARTDEV_PARITY_EN
            S_PARITY: w_txd_nxt = r_parity;
`endif
            default:  w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 16'd0;
            r_div_lat <= DIV_DEFAULT;
            r_shift   <= 8'd0;
            r_bit     <= 3'd0;
            r_txd     <= 1'b1;
            r_irq     <= 1'b1;
`ifdef UARTDEV_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_shift <= w_shift_nxt;
            r_txd   <= w_txd_nxt;
            r_irq   <= (r_state == S_IDLE) && w_empty;
            // The divisor is captured once per frame so a DIV write never disturbs a frame in flight.
            if (w_pop) begin
                r_div_lat <= r_div;
                r_cnt     <= r_div - 16'd1;
                r_bit     <= 3'd0;
`ifdef UARTDEV_PARITY_EN
                r_parity  <= ^r_mem[r_rptr];
`endif
            end else if (r_state != S_IDLE) begin
                r_cnt <= w_tick ? (r_div_lat - 16'd1) : (r_cnt - 16'd1);
                if ((r_state == S_DATA) && w_tick) begin
                    r_bit <= r_bit + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uartdev.sv
// Directed bench for uartdev: register map, frame shape/timing, FIFO full/overflow, reset abort.
// Frames carry an extra even-parity bit when UARTDEV_PARITY_EN is defined.
module tb_uartdev;

    logic        clk;
    logic        rst_n;
    logic        wen;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic        ren;
    logic [1:0]  raddr;
    logic [31:0] rdata;
    logic        txd;
    logic        irq;

    int n_checks;
    int n_pass;
    logic [7:0] tx_q[$];

    uartdev dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wen   (wen),
        .waddr (waddr),
        .wdata (wdata),
        .ren   (ren),
        .raddr (raddr),
        .rdata (rdata),
        .txd   (txd),
        .irq   (irq)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        wen   = 1'b1;
        waddr = a;
        wdata = d;
        @(negedge clk);
        wen   = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        ren   = 1'b1;
        raddr = a;
        @(negedge clk);
        ren   = 1'b0;
        check(tag, rdata, exp);
    endtask

    // Pushes every byte of tx_q on consecutive cycles; returns just after the last capturing edge.
    task automatic push_burst();
        @(negedge clk);
        wen   = 1'b1;
        waddr = 2'd0;
        for (int i = 0; i < tx_q.size(); i++) begin
            if (i > 0) @(negedge clk);
            wdata = {24'd0, tx_q[i]};
        end
        @(posedge clk);
        #1;
        wen = 1'b0;
    endtask

    // Expects the start bit on the next cycle and checks txd every cycle of the frame.
    task automatic frame_check(input logic [7:0] d, input int div, input string tag);
        logic [10:0] fr;
        int nb;
        fr      = '1;
        fr[0]   = 1'b0;
        fr[8:1] = d;
`ifdef UARTDEV_PARITY_EN
        fr[9] = ^d;
        nb    = 11;
`else
        nb    = 10;
`endif
        for (int i = 0; i < nb * div; i++) begin
            @(negedge clk);
            check($sformatf("%s_cyc%0d", tag, i), {31'd0, txd}, {31'd0, fr[i / div]});
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((irq !== 1'b1) && (n < 2000)) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, irq}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        wen      = 1'b0;
        ren      = 1'b0;
        waddr    = 2'd0;
        raddr    = 2'd0;
        wdata    = 32'd0;

        repeat (3) @(negedge clk);
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_rdata", rdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd1);
        rst_n = 1'b1;

        // Register map after reset
        bus_read(2'd1, 32'h0000_0002, "status_reset");
        bus_read(2'd2, 32'd434, "div_reset");
        raddr = 2'd1;
        @(negedge clk);
        check("rdata_hold", rdata, 32'd434);
        bus_read(2'd0, 32'd0, "read_data_zero");
        bus_read(2'd3, 32'd0, "read_rsvd_zero");
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_write(2'd3, 32'h0000_0005);
        bus_read(2'd1, 32'h0000_0002, "status_after_ro_writes");
        bus_read(2'd2, 32'd434, "div_after_rsvd_write");

        // 0x55 at DIV=4, with irq timing around the frame
        bus_write(2'd2, 32'd4);
        bus_write(2'd0, 32'h55);
        frame_check(8'h55, 4, "f55");
        check("irq_low_last_stop", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_low_after_stop", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_rise", {31'd0, irq}, 32'd1);
        check("txd_idle", {31'd0, txd}, 32'd1);
        wait_idle("idle_55");

        // DIV=0 stored as 1
        bus_write(2'd2, 32'd0);
        bus_read(2'd2, 32'd1, "div_zero_as_one");
        bus_write(2'd0, 32'hFF);
        frame_check(8'hFF, 1, "fFF");
        wait_idle("idle_ff");

        // Back-to-back frames with no idle gap
        bus_write(2'd2, 32'd2);
        tx_q = '{8'h01, 8'h80};
        push_burst();
        frame_check(8'h01, 2, "b2b0");
        frame_check(8'h80, 2, "b2b1");
        wait_idle("idle_b2b");

        // FIFO fill, overflow, sticky clear on read
        tx_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
        push_burst();
        bus_read(2'd1, 32'h0000_0805, "status_full");
        bus_write(2'd0, 32'h99);
        bus_read(2'd1, 32'h0000_080D, "status_overflow");
        bus_read(2'd1, 32'h0000_0805, "status_ovf_cleared");
        wait_idle("idle_drain");
        bus_read(2'd1, 32'h0000_0002, "status_drained");

        // DIV change mid-frame only affects the next frame
        bus_write(2'd2, 32'd8);
        tx_q = '{8'hA3, 8'h3C};
        push_burst();
        fork
            frame_check(8'hA3, 8, "fA3_div8");
            begin
                repeat (20) @(negedge clk);
                bus_write(2'd2, 32'd3);
            end
        join
        frame_check(8'h3C, 3, "f3C_div3");
        wait_idle("idle_div");

        // Reset during data bit 4 aborts the frame
        bus_write(2'd2, 32'd4);
        bus_write(2'd0, 32'h00);
        repeat (21) @(negedge clk);
        check("bit4_low", {31'd0, txd}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_txd", {31'd0, txd}, 32'd1);
        check("abort_rdata", rdata, 32'd0);
        check("abort_irq", {31'd0, irq}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_read(2'd1, 32'h0000_0002, "status_post_reset");
        bus_read(2'd2, 32'd434, "div_post_reset");
        check("irq_post_reset", {31'd0, irq}, 32'd1);

        // Final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
